// File: rtl/apb_slave_regfile.sv
// APB4 completer with a small byte-strobed register file and a read-only ID register at index 0.
// Latency: setup cycle + 1 ACCESS cycle + WAIT_CYCLES stall cycles (PREADY low) per transfer.
// Backpressure: stalls the master by holding PREADY low; an aborted ACCESS returns to IDLE with no write.
//
// Ports: PCLK/PRESETn (async active-low) clock and reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT
// APB request inputs; PREADY/PRDATA/PSLVERR APB response outputs (PRDATA/PSLVERR are 0 unless PREADY).
// Optional macro APB_SLAVE_PPROT_CHECK_EN: unprivileged (PPROT[0]=0) accesses to the upper half of the
// register file are rejected with PSLVERR. Without it PPROT is ignored.
module apb_slave_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B4_0001
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IW     = $clog2(NUM_REGS);

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << OFF) - 1);
    localparam logic [DATA_WIDTH-1:0] ID_TRUNC  = ID_VALUE[DATA_WIDTH-1:0];

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rd_val;
    logic [IW-1:0]         idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  ro_write;
    logic                  prot_err;
    logic                  err;
    logic                  wr_en;
    logic                  unused_pprot;

    // ------------------------------------------------------------------
    // Address decode and error classification
    // ------------------------------------------------------------------
    assign idx          = PADDR[OFF+IW-1:OFF];
    assign misaligned   = |(PADDR & LANE_MASK);
    assign out_of_range = |(PADDR >> (OFF + IW));
    assign ro_write     = PWRITE && (idx == '0);

`ifdef APB_SLAVE_PPROT_CHECK_EN
    // idx MSB set means idx >= NUM_REGS/2, the privileged-only half.
    assign prot_err     = !PPROT[0] && idx[IW-1];
    assign unused_pprot = ^PPROT[2:1];
`else
    assign prot_err     = 1'b0;
    assign unused_pprot = ^PPROT;
`endif

    assign err = misaligned || out_of_range || ro_write || prot_err;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        PREADY     = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    next_state = ACCESS;
                    next_cnt   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (PSEL && PENABLE) begin
                    if (cnt != '0) begin
                        next_cnt = cnt - 4'd1;
                    end else begin
                        PREADY     = 1'b1;
                        next_state = IDLE;
                    end
                end else begin
                    // Master dropped the access phase early: abandon the transfer.
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign wr_en = PREADY && PWRITE && !err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (idx == IW'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (PSTRB[b]) begin
                            regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = ID_TRUNC;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IW'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response: data and error are only meaningful in the completing cycle.
    // ------------------------------------------------------------------
    assign PRDATA  = (PREADY && !PWRITE && !err) ? rd_val : '0;
    assign PSLVERR = PREADY && err;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized self-checking bench for apb_slave_regfile: one instance with two wait states and one
// zero-wait instance share the request wires (PSEL steered by dut_sel) and are checked against an
// array model of the register file. Define APB_SLAVE_PPROT_CHECK_EN to check the privilege rule too.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA9B4_0001;

    logic        pclk;
    logic        prst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        dut_sel;   // 0: two-wait instance, 1: zero-wait instance

    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [31:0] prdata_a, prdata_b;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mdl [2][16];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_CYCLES(2)) dut_a (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel && !dut_sel), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(pready_a), .PRDATA(prdata_a), .PSLVERR(pslverr_a)
    );

    apb_slave_regfile #(.WAIT_CYCLES(0)) dut_b (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel && dut_sel), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERR(pslverr_b)
    );

    assign pready  = dut_sel ? pready_b  : pready_a;
    assign prdata  = dut_sel ? prdata_b  : prdata_a;
    assign pslverr = dut_sel ? pslverr_b : pslverr_a;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_err(input bit wr, input logic [31:0] addr, input logic [2:0] prot);
        bit e;
        e = 1'b0;
        if (addr % 4 != 0) e = 1'b1;
        if (addr >= 32'd64) e = 1'b1;
        if (wr && (addr / 4 == 0)) e = 1'b1;
`ifdef APB_SLAVE_PPROT_CHECK_EN
        if (!prot[0] && ((addr / 4) % 16 >= 8)) e = 1'b1;
`else
        if (prot == 3'b111) e = e;  // privilege bits carry no meaning in this build
`endif
        return e;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++)
                mdl[d][r] = 32'h0;
    endtask

    // Starts at a falling edge, returns at the falling edge after the completion edge with PSEL
    // still high, so a following xfer call is a back-to-back setup cycle.
    task automatic xfer(input bit d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot);
        int          waits;
        int          ix;
        bit          e;
        logic [31:0] exp_rd;
        dut_sel = d;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        waits = 0;
        while (!pready && waits < 40) begin
            @(negedge pclk);
            #1;
            waits++;
        end
        e      = exp_err(wr, addr, prot);
        ix     = (addr / 4) % 16;
        exp_rd = (!wr && !e) ? ((ix == 0) ? ID : mdl[d][ix]) : 32'h0;
        check("pready", {31'b0, pready}, 32'd1);
        check("latency", waits, d ? 32'd0 : 32'd2);
        check("pslverr", {31'b0, pslverr}, {31'b0, e});
        check("prdata", prdata, exp_rd);
        if (wr && !e)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][ix][8*b +: 8] = data[8*b +: 8];
        @(negedge pclk);
        penable = 1'b0;
    endtask

    task automatic idle();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        prst_n  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = '0;
        dut_sel = 1'b0;
        clear_model();
        repeat (2) @(negedge pclk);
        check("rst_pready_a", {31'b0, pready_a}, 32'd0);
        check("rst_prdata_a", prdata_a, 32'd0);
        check("rst_pslverr_a", {31'b0, pslverr_a}, 32'd0);
        check("rst_pready_b", {31'b0, pready_b}, 32'd0);
        prst_n = 1'b1;
        @(negedge pclk);

        // ID and empty register
        xfer(0, 0, 32'h00, 0, 4'hF, 3'b001); idle();
        xfer(0, 0, 32'h04, 0, 4'hF, 3'b001); idle();
        // strobed write
        xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'b0101, 3'b001); idle();
        xfer(0, 0, 32'h08, 0, 4'h0, 3'b001); idle();
        check("strb_merge", mdl[0][2], 32'h00AD00EF);
        // errors: ID write, misaligned, out of range
        xfer(0, 1, 32'h00, 32'h12345678, 4'hF, 3'b001); idle();
        xfer(0, 0, 32'h00, 0, 4'hF, 3'b001); idle();
        xfer(0, 0, 32'h41, 0, 4'hF, 3'b001); idle();
        xfer(0, 0, 32'h40, 0, 4'hF, 3'b001); idle();
        // zero-wait back-to-back write then read
        xfer(1, 1, 32'h0C, 32'h11111111, 4'hF, 3'b001);
        xfer(1, 0, 32'h0C, 0, 4'hF, 3'b001); idle();

        // reset during the wait cycle of a write
        dut_sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        check("wait_pready", {31'b0, pready}, 32'd0);
        prst_n = 1'b0;
        #1;
        check("rst_mid_pready", {31'b0, pready}, 32'd0);
        check("rst_mid_prdata", prdata, 32'd0);
        check("rst_mid_pslverr", {31'b0, pslverr}, 32'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        prst_n = 1'b1;
        clear_model();
        @(negedge pclk);
        xfer(0, 0, 32'h10, 0, 4'hF, 3'b001); idle();

        // privilege handling on the upper half
        xfer(0, 1, 32'h20, 32'h5A5A5A5A, 4'hF, 3'b000); idle();
        xfer(0, 0, 32'h20, 0, 4'hF, 3'b001); idle();
        xfer(0, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b001); idle();
        xfer(0, 0, 32'h20, 0, 4'hF, 3'b000); idle();

        // randomized traffic on both instances
        for (int n = 0; n < 200; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 0)
                a = ($urandom_range(0, 15) * 4) | $urandom_range(1, 3);
            else if (k == 1) begin
                a = ($urandom << 6) | ($urandom_range(0, 15) * 4);
                if (a < 64) a = a | 32'h1000;
            end else
                a = $urandom_range(0, 15) * 4;
            xfer($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) != 0) idle();
        end
        idle();

        // final sweep: every register of both instances matches the model
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++)
                xfer(d, 0, r * 4, 0, 4'h0, 3'b001);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
